// File: rtl/instruction_queue_dispatch.sv
// Instruction queue between the control unit and the execution units:
// an in-order FIFO whose head entry is offered to one unit over valid/ready.
module instruction_queue_dispatch #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              queue_we,
    input  logic [1:0]        queue_instr_type,
    input  logic [13:0]       queue_arith_instr,
    input  logic [8:0]        queue_ram_instr,
    input  logic [9:0]        queue_ld_st_instr,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [ADDR_W-1:0] main_mem_addr,
    input  logic              program_complete,
    output logic              queue_full,
    output logic [CNT_W-1:0]  queue_count,
    output logic              arith_valid,
    input  logic              arith_ready,
    output logic [13:0]       arith_instr,
    output logic              ram_valid,
    input  logic              ram_ready,
    output logic [8:0]        ram_instr,
    output logic [ADDR_W-1:0] ram_cache_addr,
    output logic [ADDR_W-1:0] ram_main_mem_addr,
    output logic              ld_st_valid,
    input  logic              ld_st_ready,
    output logic [9:0]        ld_st_instr,
    output logic [ADDR_W-1:0] ld_st_cache_addr,
    output logic              queue_overflow,
    output logic              queue_illegal,
    output logic              execution_done
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ARITH_W = 14;
    localparam int unsigned RAM_W   = 9;
    localparam int unsigned LD_ST_W = 10;

    localparam logic [1:0] TYPE_ARITH = 2'd0;
    localparam logic [1:0] TYPE_RAM   = 2'd1;
    localparam logic [1:0] TYPE_LD_ST = 2'd2;
    localparam logic [1:0] TYPE_LOOP  = 2'd3;

    typedef struct packed {
        logic [1:0]         itype;
        logic [ARITH_W-1:0] payload;
        logic [ADDR_W-1:0]  cache_addr;
        logic [ADDR_W-1:0]  main_addr;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              done_latch;

    entry_t            push_entry;
    entry_t            next_entry;
    logic              push;
    logic              pop;
    logic              head_loop;
    logic [PTR_W-1:0]  head_nxt;
    logic [PTR_W-1:0]  tail_nxt;
    logic [CNT_W-1:0]  count_after_pop;
    logic [CNT_W-1:0]  count_nxt;
    logic              done_latch_nxt;
    logic              next_busy;

    assign queue_full  = (count == CNT_W'(DEPTH));
    assign queue_count = count;

    // Keep only the payload field selected by the instruction type.
    always_comb begin
        push_entry            = '0;
        push_entry.itype      = queue_instr_type;
        push_entry.cache_addr = cache_addr;
        push_entry.main_addr  = main_mem_addr;
        case (queue_instr_type)
            TYPE_ARITH: push_entry.payload = queue_arith_instr;
            TYPE_RAM:   push_entry.payload = ARITH_W'(queue_ram_instr);
            TYPE_LD_ST: push_entry.payload = ARITH_W'(queue_ld_st_instr);
            default:    push_entry.payload = '0;
        endcase
    end

    // LOOP entries are discarded from the head without any handshake.
    assign head_loop = (count != '0) && (mem[head].itype == TYPE_LOOP);
    assign push      = queue_we && !queue_full;
    assign pop       = (arith_valid && arith_ready) || (ram_valid && ram_ready) ||
                       (ld_st_valid && ld_st_ready) || head_loop;

    always_comb begin
        head_nxt        = head + PTR_W'(pop);
        tail_nxt        = tail + PTR_W'(push);
        count_after_pop = count - CNT_W'(pop);
        count_nxt       = count_after_pop + CNT_W'(push);
        next_busy       = (count_nxt != '0);
        // An entry written this edge into an otherwise empty queue becomes the head.
        next_entry      = (count_after_pop == '0) ? push_entry : mem[head_nxt];
        done_latch_nxt  = done_latch;
        if (program_complete) begin
            done_latch_nxt = 1'b1;
        end else if (push && execution_done) begin
            done_latch_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_entry;
        end
    end

    // Pointers, flags and the registered view of the next head entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            done_latch        <= 1'b0;
            arith_valid       <= 1'b0;
            ram_valid         <= 1'b0;
            ld_st_valid       <= 1'b0;
            arith_instr       <= '0;
            ram_instr         <= '0;
            ram_cache_addr    <= '0;
            ram_main_mem_addr <= '0;
            ld_st_instr       <= '0;
            ld_st_cache_addr  <= '0;
            queue_overflow    <= 1'b0;
            queue_illegal     <= 1'b0;
            execution_done    <= 1'b0;
        end else begin
            head           <= head_nxt;
            tail           <= tail_nxt;
            count          <= count_nxt;
            done_latch     <= done_latch_nxt;
            arith_valid    <= next_busy && (next_entry.itype == TYPE_ARITH);
            ram_valid      <= next_busy && (next_entry.itype == TYPE_RAM);
            ld_st_valid    <= next_busy && (next_entry.itype == TYPE_LD_ST);
            queue_overflow <= queue_overflow || (queue_we && queue_full);
            queue_illegal  <= queue_illegal || head_loop;
            execution_done <= done_latch_nxt && !next_busy;
            if (next_busy && next_entry.itype == TYPE_ARITH) begin
                arith_instr <= next_entry.payload;
            end
            if (next_busy && next_entry.itype == TYPE_RAM) begin
                ram_instr         <= next_entry.payload[RAM_W-1:0];
                ram_cache_addr    <= next_entry.cache_addr;
                ram_main_mem_addr <= next_entry.main_addr;
            end
            if (next_busy && next_entry.itype == TYPE_LD_ST) begin
                ld_st_instr      <= next_entry.payload[LD_ST_W-1:0];
                ld_st_cache_addr <= next_entry.cache_addr;
            end
        end
    end

endmodule
